// File: rtl/sdram_frame_writer.sv
// sdram_frame_writer
// Tags incoming pixel words with a linear frame-buffer address, buffers them
// in a show-ahead FIFO and drains them to the SDRAM controller over a
// valid/ready write port. Reports FIFO fill, sticky overflow and frame
// completion.
//
// Optional feature macro: SDRAM_FRAME_WRITER_DOUBLE_BUF_EN
//   defined   -> write bank alternates FRAME_BASE0/FRAME_BASE1 on each frame wrap
//   undefined -> single bank at FRAME_BASE0, o_disp_bank stays 0
module sdram_frame_writer #(
    parameter int               DATA_W      = 16,
    parameter int               ADDR_W      = 23,
    parameter int               FIFO_DEPTH  = 16,
    parameter int               H_WORDS     = 640,
    parameter int               V_LINES     = 480,
    parameter logic [ADDR_W-1:0] FRAME_BASE0 = 23'h000000,
    parameter logic [ADDR_W-1:0] FRAME_BASE1 = 23'h080000
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_valid,
    input  logic [DATA_W-1:0]               i_data,
    input  logic                            i_frame_sync,
    input  logic                            i_clr_ovf,
    output logic                            o_wr_valid,
    output logic [ADDR_W-1:0]               o_wr_addr,
    output logic [DATA_W-1:0]               o_wr_data,
    input  logic                            i_wr_ready,
    output logic [$clog2(FIFO_DEPTH):0]     o_fill,
    output logic                            o_overflow,
    output logic                            o_frame_done,
    output logic                            o_disp_bank
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(H_WORDS * V_LINES - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

    // FIFO storage (no reset: contents are only meaningful between pointers)
    logic [ADDR_W-1:0] addr_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];

    // Counters carry one extra bit so full and empty are distinguishable
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0] pix_idx_q, pix_idx_d;
    logic              ovf_q, ovf_d;
    logic              frame_done_q, frame_done_d;
    logic              disp_bank_q, disp_bank_d;
    logic              bank;

    logic [CNT_W-1:0]  fill;
    logic              full;
    logic              wr_valid;
    logic              push;
    logic              pop;
    logic              drop;
    logic              wrap;
    logic [ADDR_W-1:0] idx_eff;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] tag_addr;

    assign fill     = wr_cnt_q - rd_cnt_q;
    assign full     = (fill == FULL_CNT);
    assign wr_valid = (fill != '0);
    assign pop      = wr_valid && i_wr_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push     = i_valid && (!full || pop);
    assign drop     = i_valid && full && !pop;

    // A frame sync restarts numbering at the word accepted in the same cycle
    assign idx_eff   = i_frame_sync ? '0 : pix_idx_q;
    assign wrap      = i_valid && (idx_eff == LAST_IDX);
    assign base_addr = bank ? FRAME_BASE1 : FRAME_BASE0;
    assign tag_addr  = base_addr + idx_eff;

    // Next-state for pointers, pixel index and status flags
    always_comb begin
        wr_cnt_d     = wr_cnt_q + CNT_W'(push);
        rd_cnt_d     = rd_cnt_q + CNT_W'(pop);
        pix_idx_d    = pix_idx_q;
        frame_done_d = wrap;
        disp_bank_d  = disp_bank_q;
        if (i_valid) begin
            // Dropped words still advance the index so later addresses stay aligned
            pix_idx_d = wrap ? '0 : idx_eff + 1'b1;
        end else if (i_frame_sync) begin
            pix_idx_d = '0;
        end
        if (wrap) begin
            disp_bank_d = bank;
        end
        // Set has priority over clear
        if (drop) begin
            ovf_d = 1'b1;
        end else if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Control state registers; reset abandons any pending writes
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            pix_idx_q    <= '0;
            ovf_q        <= 1'b0;
            frame_done_q <= 1'b0;
            disp_bank_q  <= 1'b0;
        end else begin
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            pix_idx_q    <= pix_idx_d;
            ovf_q        <= ovf_d;
            frame_done_q <= frame_done_d;
            disp_bank_q  <= disp_bank_d;
        end
    end

`ifdef SDRAM_FRAME_WRITER_DOUBLE_BUF_EN
    logic bank_q;
    assign bank = bank_q;

    // Write bank flips after each completed frame; frame sync leaves it alone
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bank_q <= 1'b0;
        end else if (wrap) begin
            bank_q <= ~bank_q;
        end
    end
`else
    assign bank = 1'b0;
`endif

    // FIFO write port
    always_ff @(posedge i_clk) begin
        if (push) begin
            addr_mem_q[wr_cnt_q[PTR_W-1:0]] <= tag_addr;
            data_mem_q[wr_cnt_q[PTR_W-1:0]] <= i_data;
        end
    end

    // Show-ahead head: outputs read as zero while the FIFO is empty
    assign o_wr_valid   = wr_valid;
    assign o_wr_addr    = wr_valid ? addr_mem_q[rd_cnt_q[PTR_W-1:0]] : '0;
    assign o_wr_data    = wr_valid ? data_mem_q[rd_cnt_q[PTR_W-1:0]] : '0;
    assign o_fill       = fill;
    assign o_overflow   = ovf_q;
    assign o_frame_done = frame_done_q;
    assign o_disp_bank  = disp_bank_q;

endmodule
